// File: rtl/cd_csr_wide.sv
`default_nettype none
// ============================================================================
// Module   : cd_csr_wide
// Purpose  : 32-bit CSR block for the CD bus controller. It holds the
//            configuration registers, the interrupt flags and mask, and the
//            sequential DAT window into the RX/TX RAMs. It also generates the
//            CTRL command pulses.
// Ports    : clk/reset_n        - rising-edge clock, async active-low reset
//            csr_*              - word-addressed CSR bus, registered read data
//            irq                - OR of (int_flag & int_mask)
//            rx_*/tx_*/cd/...   - status pulses and levels from the datapath
//            setting..div_hs    - configuration outputs
//            rx_ram_*/tx_ram_*  - RAM access and command pulses
//            has_break/ack_break- break request level and its acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module cd_csr_wide #(
    parameter logic [7:0] VERSION     = 8'h10,
    parameter int         DIV_LS      = 346,
    parameter int         DIV_HS      = 346,
    parameter int         RAM_AW      = 8,
    parameter int         CLR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        csr_address,
    input  logic [3:0]        csr_byteenable,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              csr_readdatavalid,
    output logic              irq,
    input  logic              rx_error,
    input  logic              rx_ram_lost,
    input  logic              rx_break,
    input  logic              cd,
    input  logic              tx_err,
    input  logic              rx_pending,
    input  logic              tx_pending,
    input  logic              tx_ram_full,
    input  logic              bus_idle,
    input  logic [7:0]        rx_ram_rd_len,
    input  logic [31:0]       rx_ram_rd_word,
    output logic [7:0]        setting,
    output logic [7:0]        idle_wait_len,
    output logic [1:0]        tx_pre_len,
    output logic [9:0]        tx_permit_len,
    output logic [9:0]        max_idle_len,
    output logic [7:0]        filter,
    output logic [7:0]        filter_m0,
    output logic [7:0]        filter_m1,
    output logic [15:0]       div_ls,
    output logic [15:0]       div_hs,
    output logic [RAM_AW-1:0] rx_ram_rd_addr,
    output logic              tx_ram_wr_en,
    output logic [RAM_AW-1:0] tx_ram_wr_addr,
    output logic [3:0]        tx_ram_wr_be,
    output logic [31:0]       tx_ram_wr_data,
    output logic              rx_clean_all,
    output logic              rx_ram_rd_done,
    output logic              tx_abort,
    output logic              tx_drop,
    output logic              tx_ram_wr_done,
    output logic              has_break,
    input  logic              ack_break
);

    // Flags that latch until cleared: rx_break, rx_lost, rx_error, cd, tx_err, bus_err
    localparam logic [15:0] c_STICKY_MASK = 16'h01CE;

    logic [31:0]       w_mask;
    logic [31:0]       w_reg0, w_reg1, w_reg2, w_reg3, w_reg4, w_reg5;
    logic [31:0]       w_reg0_new, w_reg1_new, w_reg2_new, w_reg3_new, w_reg4_new, w_reg5_new;
    logic [15:0]       w_div_ls_new, w_div_hs_new;
    logic [15:0]       w_int_flag, w_set, w_clr;
    logic [31:0]       w_rdata;
    logic              w_dat_wr, w_dat_ok, w_dat_rd, w_ctrl;
    logic [RAM_AW-1:0] w_wr_inc;

    logic [15:0]       r_int_mask, r_sticky;
    logic [31:0]       r_readdata;
    logic              r_rvalid;

    // Byte-lane expansion used to merge writes into the current register image
    assign w_mask = {{8{csr_byteenable[3]}}, {8{csr_byteenable[2]}},
                     {8{csr_byteenable[1]}}, {8{csr_byteenable[0]}}};

    assign w_reg0 = {16'b0, setting, VERSION};
    assign w_reg1 = {6'b0, tx_permit_len, 6'b0, tx_pre_len, idle_wait_len};
    assign w_reg2 = {8'b0, filter, 6'b0, max_idle_len};
    assign w_reg3 = {16'b0, filter_m1, filter_m0};
    assign w_reg4 = {div_hs, div_ls};
    assign w_reg5 = {16'b0, r_int_mask};

    assign w_reg0_new = (w_reg0 & ~w_mask) | (csr_writedata & w_mask);
    assign w_reg1_new = (w_reg1 & ~w_mask) | (csr_writedata & w_mask);
    assign w_reg2_new = (w_reg2 & ~w_mask) | (csr_writedata & w_mask);
    assign w_reg3_new = (w_reg3 & ~w_mask) | (csr_writedata & w_mask);
    assign w_reg4_new = (w_reg4 & ~w_mask) | (csr_writedata & w_mask);
    assign w_reg5_new = (w_reg5 & ~w_mask) | (csr_writedata & w_mask);

    // Divisors below 2 are meaningless; clamp the merged value
    assign w_div_ls_new = (w_reg4_new[15:0]  < 16'd2) ? 16'd2 : w_reg4_new[15:0];
    assign w_div_hs_new = (w_reg4_new[31:16] < 16'd2) ? 16'd2 : w_reg4_new[31:16];

    // DAT window: only contiguous low-aligned lane patterns are legal writes
    assign w_dat_wr = csr_write && (csr_address == 4'h7);
    assign w_dat_ok = w_dat_wr && ((csr_byteenable == 4'b0001) || (csr_byteenable == 4'b0011) ||
                                   (csr_byteenable == 4'b0111) || (csr_byteenable == 4'b1111));
    assign w_dat_rd = csr_read && (csr_address == 4'h7);
    assign w_ctrl   = csr_write && (csr_address == 4'h8) && csr_byteenable[0];
    assign w_wr_inc = csr_byteenable[3] ? RAM_AW'(4) :
                      csr_byteenable[2] ? RAM_AW'(3) :
                      csr_byteenable[1] ? RAM_AW'(2) : RAM_AW'(1);

    assign tx_ram_wr_en   = w_dat_ok;
    assign tx_ram_wr_be   = csr_byteenable;
    assign tx_ram_wr_data = csr_writedata;

    always_comb begin
        w_int_flag       = r_sticky;
        w_int_flag[0]    = rx_pending;
        w_int_flag[4]    = ~tx_ram_full;
        w_int_flag[5]    = ~tx_pending;
        w_int_flag[9]    = bus_idle;
        w_int_flag[10]   = ~bus_idle;
    end

    assign irq = |(w_int_flag & r_int_mask);

    always_comb begin
        w_set    = 16'b0;
        w_set[1] = rx_break;
        w_set[2] = rx_ram_lost;
        w_set[3] = rx_error;
        w_set[6] = cd;
        w_set[7] = tx_err;
        w_set[8] = w_dat_wr && !w_dat_ok;
        w_clr    = 16'b0;
        if (CLR_ON_READ != 0) begin
            // Clear only what the reader actually saw
            if (csr_read && (csr_address == 4'h6))
                w_clr = r_sticky & c_STICKY_MASK;
        end else begin
            if (csr_write && (csr_address == 4'h6))
                w_clr = csr_writedata[15:0] & w_mask[15:0] & c_STICKY_MASK;
        end
    end

    always_comb begin
        w_rdata = 32'b0;
        case (csr_address)
            4'h0:    w_rdata = w_reg0;
            4'h1:    w_rdata = w_reg1;
            4'h2:    w_rdata = w_reg2;
            4'h3:    w_rdata = w_reg3;
            4'h4:    w_rdata = w_reg4;
            4'h5:    w_rdata = w_reg5;
            4'h6:    w_rdata = {8'b0, rx_ram_rd_len, w_int_flag};
            4'h7:    w_rdata = rx_ram_rd_word;
            default: w_rdata = 32'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            setting        <= 8'h10;
            idle_wait_len  <= 8'd10;
            tx_pre_len     <= 2'd1;
            tx_permit_len  <= 10'd20;
            max_idle_len   <= 10'd200;
            filter         <= 8'hff;
            filter_m0      <= 8'hff;
            filter_m1      <= 8'hff;
            div_ls         <= 16'(DIV_LS);
            div_hs         <= 16'(DIV_HS);
            r_int_mask     <= 16'b0;
            r_sticky       <= 16'b0;
            rx_ram_rd_addr <= '0;
            tx_ram_wr_addr <= '0;
            rx_clean_all   <= 1'b0;
            rx_ram_rd_done <= 1'b0;
            tx_abort       <= 1'b0;
            tx_drop        <= 1'b0;
            tx_ram_wr_done <= 1'b0;
            has_break      <= 1'b0;
            r_readdata     <= 32'b0;
            r_rvalid       <= 1'b0;
        end else begin
            if (csr_write) begin
                case (csr_address)
                    4'h0: setting <= w_reg0_new[15:8];
                    4'h1: begin
                        idle_wait_len <= w_reg1_new[7:0];
                        tx_pre_len    <= w_reg1_new[9:8];
                        tx_permit_len <= w_reg1_new[25:16];
                    end
                    4'h2: begin
                        max_idle_len <= w_reg2_new[9:0];
                        filter       <= w_reg2_new[23:16];
                    end
                    4'h3: begin
                        filter_m0 <= w_reg3_new[7:0];
                        filter_m1 <= w_reg3_new[15:8];
                    end
                    4'h4: begin
                        div_ls <= w_div_ls_new;
                        div_hs <= w_div_hs_new;
                    end
                    4'h5:    r_int_mask <= w_reg5_new[15:0];
                    default: ;
                endcase
            end

            // Set wins over a coincident clear
            r_sticky <= ((r_sticky & ~w_clr) | w_set) & c_STICKY_MASK;

            // CTRL reset of both pointers overrides any same-cycle advance
            if (w_ctrl) begin
                rx_ram_rd_addr <= '0;
                tx_ram_wr_addr <= '0;
            end else begin
                if (w_dat_rd) rx_ram_rd_addr <= rx_ram_rd_addr + RAM_AW'(4);
                if (w_dat_ok) tx_ram_wr_addr <= tx_ram_wr_addr + w_wr_inc;
            end

            rx_clean_all   <= w_ctrl && csr_writedata[7];
            rx_ram_rd_done <= w_ctrl && csr_writedata[4];
            tx_abort       <= w_ctrl && csr_writedata[3];
            tx_drop        <= w_ctrl && csr_writedata[2];
            tx_ram_wr_done <= w_ctrl && csr_writedata[0];

            if (w_ctrl && csr_writedata[1]) has_break <= 1'b1;
            else if (ack_break)             has_break <= 1'b0;

            if (csr_read) r_readdata <= w_rdata;
            r_rvalid <= csr_read;
        end
    end

    assign csr_readdata      = r_readdata;
    assign csr_readdatavalid = r_rvalid;

    // Merged-image bits that do not map onto any field
    logic w_unused;
    assign w_unused = &{1'b0, w_reg0_new[31:16], w_reg0_new[7:0], w_reg1_new[31:26],
                        w_reg1_new[15:10], w_reg2_new[31:24], w_reg2_new[15:10],
                        w_reg3_new[31:16], w_reg5_new[31:16]};

endmodule
`default_nettype wire

// File: tb/tb_cd_csr_wide.sv
`default_nettype none
// ============================================================================
// Module   : tb_cd_csr_wide
// Purpose  : Self-checking bench for cd_csr_wide. Two instances share one bus:
//            u0 uses write-one-to-clear flags, u1 clear-on-read flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cd_csr_wide;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  csr_address = '0, csr_byteenable = '0;
    logic        csr_read = 1'b0, csr_write = 1'b0;
    logic [31:0] csr_writedata = '0, rx_ram_rd_word = '0;
    logic        rx_error = 0, rx_ram_lost = 0, rx_break = 0, cd = 0, tx_err = 0;
    logic        rx_pending = 0, tx_pending = 0, tx_ram_full = 0, bus_idle = 0, ack_break = 0;
    logic [7:0]  rx_ram_rd_len = '0;

    // u0 outputs
    logic [31:0] csr_readdata, tx_ram_wr_data;
    logic        csr_readdatavalid, irq, tx_ram_wr_en, has_break;
    logic        rx_clean_all, rx_ram_rd_done, tx_abort, tx_drop, tx_ram_wr_done;
    logic [7:0]  setting, idle_wait_len, filter, filter_m0, filter_m1;
    logic [1:0]  tx_pre_len;
    logic [9:0]  tx_permit_len, max_idle_len;
    logic [15:0] div_ls, div_hs;
    logic [7:0]  rx_ram_rd_addr, tx_ram_wr_addr;
    logic [3:0]  tx_ram_wr_be;

    // u1 outputs
    logic [31:0] rdata_1, wr_data_1;
    logic        rvalid_1, irq_1, wr_en_1, has_break_1;
    logic        clean_1, rd_done_1, abort_1, drop_1, wr_done_1;
    logic [7:0]  setting_1, idle_1, filter_1, m0_1, m1_1;
    logic [1:0]  pre_1;
    logic [9:0]  permit_1, max_idle_1;
    logic [15:0] div_ls_1, div_hs_1;
    logic [7:0]  rd_addr_1, wr_addr_1;
    logic [3:0]  wr_be_1;

    always #5 clk = ~clk;

    cd_csr_wide #(.CLR_ON_READ(0)) u0 (
        .clk(clk), .reset_n(reset_n), .csr_address(csr_address), .csr_byteenable(csr_byteenable),
        .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid), .irq(irq),
        .rx_error(rx_error), .rx_ram_lost(rx_ram_lost), .rx_break(rx_break), .cd(cd), .tx_err(tx_err),
        .rx_pending(rx_pending), .tx_pending(tx_pending), .tx_ram_full(tx_ram_full), .bus_idle(bus_idle),
        .rx_ram_rd_len(rx_ram_rd_len), .rx_ram_rd_word(rx_ram_rd_word),
        .setting(setting), .idle_wait_len(idle_wait_len), .tx_pre_len(tx_pre_len),
        .tx_permit_len(tx_permit_len), .max_idle_len(max_idle_len), .filter(filter),
        .filter_m0(filter_m0), .filter_m1(filter_m1), .div_ls(div_ls), .div_hs(div_hs),
        .rx_ram_rd_addr(rx_ram_rd_addr), .tx_ram_wr_en(tx_ram_wr_en), .tx_ram_wr_addr(tx_ram_wr_addr),
        .tx_ram_wr_be(tx_ram_wr_be), .tx_ram_wr_data(tx_ram_wr_data),
        .rx_clean_all(rx_clean_all), .rx_ram_rd_done(rx_ram_rd_done), .tx_abort(tx_abort),
        .tx_drop(tx_drop), .tx_ram_wr_done(tx_ram_wr_done), .has_break(has_break), .ack_break(ack_break)
    );

    cd_csr_wide #(.CLR_ON_READ(1)) u1 (
        .clk(clk), .reset_n(reset_n), .csr_address(csr_address), .csr_byteenable(csr_byteenable),
        .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_readdata(rdata_1), .csr_readdatavalid(rvalid_1), .irq(irq_1),
        .rx_error(rx_error), .rx_ram_lost(rx_ram_lost), .rx_break(rx_break), .cd(cd), .tx_err(tx_err),
        .rx_pending(rx_pending), .tx_pending(tx_pending), .tx_ram_full(tx_ram_full), .bus_idle(bus_idle),
        .rx_ram_rd_len(rx_ram_rd_len), .rx_ram_rd_word(rx_ram_rd_word),
        .setting(setting_1), .idle_wait_len(idle_1), .tx_pre_len(pre_1),
        .tx_permit_len(permit_1), .max_idle_len(max_idle_1), .filter(filter_1),
        .filter_m0(m0_1), .filter_m1(m1_1), .div_ls(div_ls_1), .div_hs(div_hs_1),
        .rx_ram_rd_addr(rd_addr_1), .tx_ram_wr_en(wr_en_1), .tx_ram_wr_addr(wr_addr_1),
        .tx_ram_wr_be(wr_be_1), .tx_ram_wr_data(wr_data_1),
        .rx_clean_all(clean_1), .rx_ram_rd_done(rd_done_1), .tx_abort(abort_1),
        .tx_drop(drop_1), .tx_ram_wr_done(wr_done_1), .has_break(has_break_1), .ack_break(ack_break)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One bus cycle; returns at the falling edge after the capturing rising edge
    task automatic bus_cycle(input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd,
                             input logic rd, input logic wr);
        @(negedge clk);
        csr_address = a; csr_byteenable = be; csr_writedata = wd;
        csr_read = rd; csr_write = wr;
        @(negedge clk);
        csr_read = 1'b0; csr_write = 1'b0;
    endtask

    task automatic dat_wr(input logic [3:0] be, input logic [31:0] wd,
                          input logic exp_en, input logic [7:0] exp_next);
        @(negedge clk);
        csr_address = 4'h7; csr_byteenable = be; csr_writedata = wd; csr_write = 1'b1;
        #1;
        chk("dat_wr_en", tx_ram_wr_en, exp_en);
        chk("dat_wr_be_data", {tx_ram_wr_be, tx_ram_wr_data[27:0]}, {be, wd[27:0]});
        @(negedge clk);
        csr_write = 1'b0;
        chk("dat_wr_addr", tx_ram_wr_addr, exp_next);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{"div_hs_clamp",   4'h4, 4'b1111, 32'h0001_0100, 32'h0002_0100};
        vt[1]  = '{"lane1_only",     4'h1, 4'b0010, 32'h0000_0300, 32'h0014_030A};
        vt[2]  = '{"version_ro",     4'h0, 4'b1111, 32'hFFFF_FF55, 32'h0000_FF10};
        vt[3]  = '{"lanes_0_2",      4'h2, 4'b0101, 32'h1234_5678, 32'h0034_0078};
        vt[4]  = '{"filter_m",       4'h3, 4'b1111, 32'hAAAA_BBCC, 32'h0000_BBCC};
        vt[5]  = '{"div_ls_clamp",   4'h4, 4'b0011, 32'h0000_0001, 32'h0002_0002};
        vt[6]  = '{"div_hs_upper",   4'h4, 4'b1100, 32'h1234_0000, 32'h1234_0002};
        vt[7]  = '{"int_mask",       4'h5, 4'b1111, 32'h0003_0001, 32'h0000_0001};
        vt[8]  = '{"unmapped",       4'h9, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[9]  = '{"mixed_lanes",    4'h1, 4'b1101, 32'hFFFF_FFFF, 32'h03FF_03FF};
        vt[10] = '{"div_ls_lane1",   4'h4, 4'b0010, 32'h0000_0100, 32'h1234_0102};
        vt[11] = '{"div_post_merge", 4'h4, 4'b0001, 32'h0000_0000, 32'h1234_0100};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_rvalid", csr_readdatavalid, 1'b0);
        chk("rst_rdata", csr_readdata, 32'h0);
        chk("rst_setting_idle", {16'b0, setting, idle_wait_len}, 32'h0000_100A);
        chk("rst_pre_permit", {20'b0, tx_pre_len, tx_permit_len}, {20'b0, 2'd1, 10'd20});
        chk("rst_maxidle_filter", {14'b0, max_idle_len, filter}, {14'b0, 10'd200, 8'hFF});
        chk("rst_filter_m", {16'b0, filter_m1, filter_m0}, 32'h0000_FFFF);
        chk("rst_div", {div_hs, div_ls}, {16'd346, 16'd346});
        chk("rst_addrs", {16'b0, rx_ram_rd_addr, tx_ram_wr_addr}, 32'h0);
        chk("rst_pulses", {24'b0, irq, has_break, rx_clean_all, rx_ram_rd_done, tx_abort,
                           tx_drop, tx_ram_wr_done, tx_ram_wr_en}, 32'h0);
        reset_n = 1'b1;

        // ---------------- table: write then read back ----------------
        for (int i = 0; i < 12; i++) begin
            bus_cycle(vt[i].a, vt[i].be, vt[i].wd, 1'b0, 1'b1);
            bus_cycle(vt[i].a, 4'hF, 32'h0, 1'b1, 1'b0);
            chk({vt[i].name, "_valid"}, csr_readdatavalid, 1'b1);
            chk(vt[i].name, csr_readdata, vt[i].exp);
        end
        @(negedge clk);
        chk("valid_one_cycle", csr_readdatavalid, 1'b0);
        chk("out_div", {div_hs, div_ls}, 32'h1234_0100);
        chk("out_cfg", {setting, idle_wait_len, max_idle_len[7:0], filter}, 32'hFFFF_7834);
        chk("out_pre_permit", {20'b0, tx_pre_len, tx_permit_len}, {20'b0, 2'd3, 10'h3FF});

        // ---------------- simultaneous read and write ----------------
        bus_cycle(4'h0, 4'b0010, 32'h0000_7700, 1'b1, 1'b1);
        chk("rw_old_data", csr_readdata, 32'h0000_FF10);
        chk("rw_new_setting", setting, 8'h77);

        // ---------------- interrupt flags / levels ----------------
        rx_pending = 1'b1; bus_idle = 1'b1; rx_ram_rd_len = 8'h5A;
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("int_flag_levels", csr_readdata, 32'h005A_0231);
        chk("irq_rx_pending", irq, 1'b1);
        rx_pending = 1'b0; bus_idle = 1'b0;
        #1;
        chk("irq_comb_drop", irq, 1'b0);

        // ---------------- DAT writes and bus_err ----------------
        dat_wr(4'b1111, 32'hDEADBEEF, 1'b1, 8'd4);
        dat_wr(4'b0011, 32'h0000_1234, 1'b1, 8'd6);
        dat_wr(4'b0101, 32'h0055_0055, 1'b0, 8'd6);
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("bus_err_flag", csr_readdata, 32'h005A_0530);
        bus_cycle(4'h5, 4'b0011, 32'h0000_0100, 1'b0, 1'b1);
        chk("irq_bus_err", irq, 1'b1);
        bus_cycle(4'h6, 4'b0001, 32'h0000_0100, 1'b0, 1'b1);
        chk("w1c_lane_disabled", irq, 1'b1);
        bus_cycle(4'h6, 4'b0010, 32'h0000_0100, 1'b0, 1'b1);
        chk("w1c_bus_err", irq, 1'b0);

        // ---------------- W1C: set wins over same-cycle clear ----------------
        @(negedge clk);
        cd = 1'b1; csr_address = 4'h6; csr_byteenable = 4'b0001;
        csr_writedata = 32'h40; csr_write = 1'b1;
        @(negedge clk);
        cd = 1'b0; csr_write = 1'b0;
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("cd_set_wins", csr_readdata[6], 1'b1);
        bus_cycle(4'h6, 4'b0001, 32'h40, 1'b0, 1'b1);
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("cd_cleared", csr_readdata[6], 1'b0);

        // ---------------- clear-on-read (u1) ----------------
        @(negedge clk); rx_break = 1'b1;
        @(negedge clk); rx_break = 1'b0;
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("cor_first_read", rdata_1[1], 1'b1);
        chk("w1c_read_first", csr_readdata[1], 1'b1);
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("cor_cleared", rdata_1[1], 1'b0);
        chk("w1c_read_no_clear", csr_readdata[1], 1'b1);
        @(negedge clk); rx_break = 1'b1;
        @(negedge clk); rx_break = 1'b0;
        @(negedge clk);
        csr_address = 4'h6; csr_byteenable = 4'hF; csr_read = 1'b1; rx_break = 1'b1;
        @(negedge clk);
        csr_read = 1'b0; rx_break = 1'b0;
        chk("cor_read_pulse", rdata_1[1], 1'b1);
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("cor_set_wins", rdata_1[1], 1'b1);
        bus_cycle(4'h6, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("cor_final_clear", rdata_1[1], 1'b0);

        // ---------------- has_break ----------------
        bus_cycle(4'h8, 4'b0001, 32'h02, 1'b0, 1'b1);
        chk("break_set", has_break, 1'b1);
        chk("ctrl_zero_tx_addr", tx_ram_wr_addr, 8'd0);
        chk("break_no_pulses", {rx_clean_all, rx_ram_rd_done, tx_abort, tx_drop, tx_ram_wr_done}, 5'b0);
        @(negedge clk); ack_break = 1'b1;
        @(negedge clk); ack_break = 1'b0;
        chk("break_ack", has_break, 1'b0);
        @(negedge clk);
        ack_break = 1'b1; csr_address = 4'h8; csr_byteenable = 4'b0001;
        csr_writedata = 32'h02; csr_write = 1'b1;
        @(negedge clk);
        ack_break = 1'b0; csr_write = 1'b0;
        chk("break_set_wins", has_break, 1'b1);
        bus_cycle(4'h8, 4'b0010, 32'h0000_FFFF, 1'b0, 1'b1);
        chk("ctrl_lane0_off", {rx_clean_all, tx_abort, tx_ram_wr_done}, 3'b000);

        // ---------------- DAT read, wrap, CTRL pulses ----------------
        rx_ram_rd_word = 32'hCAFE_F00D;
        bus_cycle(4'h7, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("dat_read_data", csr_readdata, 32'hCAFE_F00D);
        chk("dat_read_addr", rx_ram_rd_addr, 8'd4);
        for (int i = 0; i < 63; i++) bus_cycle(4'h7, 4'hF, i, 1'b0, 1'b1);
        bus_cycle(4'h7, 4'b0011, 32'h0, 1'b0, 1'b1);
        chk("tx_addr_254", tx_ram_wr_addr, 8'd254);
        bus_cycle(4'h7, 4'hF, 32'h0, 1'b0, 1'b1);
        chk("tx_addr_wrap", tx_ram_wr_addr, 8'd2);
        bus_cycle(4'h8, 4'b0001, 32'h11, 1'b0, 1'b1);
        chk("ctrl_11_pulses", {rx_clean_all, rx_ram_rd_done, tx_abort, tx_drop, tx_ram_wr_done}, 5'b01001);
        chk("ctrl_11_addrs", {rx_ram_rd_addr, tx_ram_wr_addr}, 16'h0);
        @(negedge clk);
        chk("ctrl_11_one_cycle", {rx_ram_rd_done, tx_ram_wr_done}, 2'b00);
        bus_cycle(4'h8, 4'b0001, 32'h8D, 1'b0, 1'b1);
        chk("ctrl_8d_pulses", {rx_clean_all, rx_ram_rd_done, tx_abort, tx_drop, tx_ram_wr_done}, 5'b10111);

        // ---------------- reset mid-read ----------------
        @(negedge clk);
        csr_address = 4'h0; csr_byteenable = 4'hF; csr_read = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_aborts_valid", csr_readdatavalid, 1'b0);
        chk("reset_setting", setting, 8'h10);
        @(negedge clk);
        csr_read = 1'b0; reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cd_csr_wide.md
CD_CSR_WIDE -- requirements
Module: cd_csr_wide

Interface
REQ-001 Parameters SHALL be: VERSION 8'h10, CSR version; DIV_LS 346, low-speed divisor reset value; DIV_HS 346, high-speed divisor reset value; RAM_AW 8, RAM byte-address width; CLR_ON_READ 0 (1 = sticky flags clear on INT_FLAG read, 0 = write-one-to-clear).
REQ-002 Clock and reset SHALL be: clk in 1, rising-edge clock; reset_n in 1, asynchronous, active-low reset.
REQ-003 Bus ports SHALL be: csr_address in 4, word index; csr_byteenable in 4; csr_read in 1; csr_write in 1; csr_writedata in 32; csr_readdata out 32, registered; csr_readdatavalid out 1; irq out 1.
REQ-004 Status inputs SHALL be: rx_error, rx_ram_lost, rx_break, cd, tx_err in 1, one-cycle pulses; rx_pending, tx_pending, tx_ram_full, bus_idle in 1, levels; rx_ram_rd_len in 8; rx_ram_rd_word in 32, combinational data at rx_ram_rd_addr.
REQ-005 Config outputs SHALL be: setting in 8, and idle_wait_len 8, tx_pre_len 2, tx_permit_len 10, max_idle_len 10, filter 8, filter_m0 8, filter_m1 8, div_ls 16, div_hs 16, all out.
REQ-006 RAM and control outputs SHALL be: rx_ram_rd_addr out RAM_AW; tx_ram_wr_en out 1; tx_ram_wr_addr out RAM_AW; tx_ram_wr_be out 4; tx_ram_wr_data out 32, equal to csr_writedata; rx_clean_all, rx_ram_rd_done, tx_abort, tx_drop, tx_ram_wr_done out 1, pulses; has_break out 1, level; ack_break in 1.

Function
REQ-007 Register map SHALL be: 0x0 [7:0] VERSION RO, [15:8] setting RW; 0x1 [7:0] idle_wait_len, [9:8] tx_pre_len, [25:16] tx_permit_len; 0x2 [9:0] max_idle_len, [23:16] filter; 0x3 [7:0] filter_m0, [15:8] filter_m1; 0x4 [15:0] div_ls, [31:16] div_hs; 0x5 [15:0] int_mask; 0x6 [15:0] int_flag, [23:16] rx_ram_rd_len RO; 0x7 DAT; 0x8 CTRL WO; all unlisted bits and addresses SHALL read 0 and ignore writes.
REQ-008 Each write SHALL update only the field bits inside enabled byte lanes, in the same cycle, with no shadow/staging register.
REQ-009 Any written div_ls or div_hs value below 2 SHALL be stored as 2, evaluated on the post-merge 16-bit value.
REQ-010 csr_readdata and csr_readdatavalid SHALL be registered: valid is asserted exactly 1 cycle after csr_read and data is sampled from the read cycle; read side effects occur in the read cycle.
REQ-011 int_flag SHALL be: [0] rx_pending; [1] rx_break sticky; [2] rx_lost sticky; [3] rx_error sticky; [4] ~tx_ram_full; [5] ~tx_pending; [6] cd sticky; [7] tx_err sticky; [8] bus_err sticky; [9] bus_idle; [10] ~bus_idle; [15:11] 0.
REQ-012 irq SHALL be the combinational OR of (int_flag & int_mask).
REQ-013 When CLR_ON_READ=0, a write to 0x6 SHALL clear each sticky flag whose writedata bit is 1 in an enabled lane; reads have no side effect.
REQ-014 When CLR_ON_READ=1, a read of 0x6 SHALL clear only those sticky flags that were 1 in the returned data.
REQ-015 When a flag's set pulse and its clear occur in the same cycle, set SHALL win.
REQ-016 A DAT write SHALL be legal only for byteenable 0001, 0011, 0111 or 1111: it drives tx_ram_wr_en=1 and tx_ram_wr_be=byteenable at the current tx_ram_wr_addr, then advances tx_ram_wr_addr by 1-4 modulo 2^RAM_AW.
REQ-017 A DAT write with any other byteenable, including 0000, SHALL produce no RAM write and no advance, and SHALL set bus_err.
REQ-018 A DAT read SHALL return rx_ram_rd_word and advance rx_ram_rd_addr by 4 modulo 2^RAM_AW.
REQ-019 A CTRL write with lane 0 enabled SHALL pulse for exactly 1 cycle: bit7 rx_clean_all, bit4 rx_ram_rd_done, bit3 tx_abort, bit2 tx_drop, bit0 tx_ram_wr_done. Bit1 SHALL set has_break.
REQ-020 Any CTRL write with lane 0 enabled SHALL zero both rx_ram_rd_addr and tx_ram_wr_addr, and this SHALL take priority over a same-cycle advance.
REQ-021 ack_break SHALL clear has_break; if it coincides with a CTRL bit1 set, the set SHALL win.
REQ-022 Simultaneous csr_read and csr_write SHALL both take effect.

Reset
REQ-023 Reset SHALL set: setting 8'h10; idle_wait_len 10; tx_pre_len 1; tx_permit_len 20; max_idle_len 200; filter, filter_m0 and filter_m1 8'hff; div_ls DIV_LS; div_hs DIV_HS; int_mask 0; all sticky flags 0; both RAM addresses 0; all pulses 0; has_break 0; csr_readdata 0; csr_readdatavalid 0.
REQ-024 Assertion of reset mid-transfer SHALL take effect immediately and abort any pending readdatavalid.

Verification
REQ-025 Write 0x4 with data 0x0001_0100 and byteenable 1111, then read 0x4 -> readdatavalid 1 cycle later; data 0x0002_0100 (div_hs clamped to 2).
REQ-026 Write 0x1 with byteenable 0010, data 0x0000_0300 -> tx_pre_len=3; idle_wait_len stays 10; tx_permit_len stays 20.
REQ-027 DAT writes with byteenable 1111, then 0011, then 0101 -> tx_ram_wr_addr 4, then 6, then 6; third write gives no tx_ram_wr_en; bus_err=1; irq=1 when int_mask bit8=1.
REQ-028 CLR_ON_READ=0: pulse cd in the same cycle as a write of 0x40 to 0x6 -> cd flag remains 1; a second write of 0x40 clears it.
REQ-029 CLR_ON_READ=1: pulse rx_break, read 0x6 -> returned bit1=1 and flag cleared; a rx_break pulse in the read cycle keeps the flag at 1.
REQ-030 With tx_ram_wr_addr 2^RAM_AW-2, a 1111 DAT write gives tx_ram_wr_addr 2 (wrap); a CTRL write of 0x11 then pulses rx_ram_rd_done and tx_ram_wr_done for 1 cycle and zeroes both addresses.
